// File: rtl/hpdl_pkg.sv
// Shared constants, FSM encoding and strobe-decode helpers for the HPDL-1414 bus receiver.
package hpdl_pkg;

    localparam int HPDL_NUM_DEV   = 4;
    localparam int HPDL_NUM_DIGIT = 4;
    localparam int HPDL_DATA_W    = 7;
    localparam int HPDL_ADDR_W    = 4;
    localparam int HPDL_NUM_CHAR  = HPDL_NUM_DEV * HPDL_NUM_DIGIT;

    localparam logic [HPDL_DATA_W-1:0] HPDL_BLANK_CHAR = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_DRAIN = 2'd2
    } hpdl_state_t;

    // Number of strobes currently asserted (low).
    function automatic logic [2:0] count_low(input logic [HPDL_NUM_DEV-1:0] wr_n);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < HPDL_NUM_DEV; i++)
            n = n + {2'b00, ~wr_n[i]};
        return n;
    endfunction

    // Index of the lowest asserted strobe; only meaningful when exactly one is low.
    function automatic logic [1:0] low_index(input logic [HPDL_NUM_DEV-1:0] wr_n);
        logic [1:0] idx;
        idx = '0;
        for (int i = HPDL_NUM_DEV - 1; i >= 0; i--)
            if (!wr_n[i])
                idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/hpdl_sync.sv
// N-bit multi-stage synchronizer with async active-low reset and per-bit reset value.
module hpdl_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pipe <= {STAGES{RST_VAL}};
        else
            r_pipe <= {r_pipe[STAGES-2:0], i_d};
    end

    assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/hpdl_bus_receiver.sv
// Display-side HPDL-1414 bus receiver: synchronizes the async write bus, validates
// strobes and mirrors accepted writes into a 16-character shadow RAM.
module hpdl_bus_receiver
    import hpdl_pkg::*;
#(
    parameter int                     MIN_WR_LOW  = 2,
    parameter int                     SYNC_STAGES = 2,
    parameter logic [HPDL_DATA_W-1:0] BLANK_CHAR  = HPDL_BLANK_CHAR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [HPDL_DATA_W-1:0]   hpdl_d,
    input  logic [1:0]               hpdl_a,
    input  logic [HPDL_NUM_DEV-1:0]  hpdl_wr_n,
    input  logic [HPDL_ADDR_W-1:0]   rd_addr,
    output logic [HPDL_DATA_W-1:0]   rd_char,
    output logic                     wr_valid,
    output logic [HPDL_ADDR_W-1:0]   wr_addr,
    output logic [HPDL_DATA_W-1:0]   wr_char,
    output logic                     err_runt,
    output logic                     err_collision,
    input  logic                     err_clr,
    input  logic                     blank
);

    localparam int BUS_W = HPDL_NUM_DEV + 2 + HPDL_DATA_W;
    localparam int CNT_W = (MIN_WR_LOW < 2) ? 1 : $clog2(MIN_WR_LOW + 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_WR_LOW);

    // Idle bus: all strobes high, data/address zero.
    localparam logic [BUS_W-1:0] BUS_IDLE = {{HPDL_NUM_DEV{1'b1}}, 2'b00, {HPDL_DATA_W{1'b0}}};

    logic [BUS_W-1:0]        w_bus_raw;
    logic [BUS_W-1:0]        w_bus_s;
    logic [HPDL_NUM_DEV-1:0] w_s_wr_n;
    logic [1:0]              w_s_a;
    logic [HPDL_DATA_W-1:0]  w_s_d;

    assign w_bus_raw = {hpdl_wr_n, hpdl_a, hpdl_d};

    hpdl_sync #(
        .WIDTH   (BUS_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (BUS_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_bus_raw),
        .o_q   (w_bus_s)
    );

    assign {w_s_wr_n, w_s_a, w_s_d} = w_bus_s;

    hpdl_state_t                                   r_state;
    logic [1:0]                                    r_dev;
    logic [CNT_W-1:0]                              r_low_cnt;
    logic [1:0]                                    r_hold_a;
    logic [HPDL_DATA_W-1:0]                        r_hold_d;
    logic [HPDL_NUM_CHAR-1:0][HPDL_DATA_W-1:0]     r_ram;

    logic [2:0]              w_n_low;
    logic [HPDL_NUM_DEV-1:0] w_sel_mask;
    logic                    w_sel_low;
    logic                    w_other_low;
    logic                    w_rise;
    logic                    w_commit;
    logic                    w_ram_we;
    logic [HPDL_ADDR_W-1:0]  w_waddr;

    assign w_n_low     = count_low(w_s_wr_n);
    assign w_sel_mask  = HPDL_NUM_DEV'(1) << r_dev;
    assign w_sel_low   = ~w_s_wr_n[r_dev];
    assign w_other_low = |(~w_s_wr_n & ~w_sel_mask);
    assign w_rise      = (r_state == ST_LOW) && !w_sel_low && !w_other_low;
    assign w_commit    = w_rise && (r_low_cnt >= CNT_MIN);
    assign w_ram_we    = w_commit && !blank;
    assign w_waddr     = {r_dev, r_hold_a};

    // Strobe FSM; error-setting events override a same-cycle err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_dev         <= '0;
            r_low_cnt     <= '0;
            r_hold_a      <= '0;
            r_hold_d      <= '0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_char       <= BLANK_CHAR;
            err_runt      <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            wr_valid      <= 1'b0;
            err_runt      <= err_runt & ~err_clr;
            err_collision <= err_collision & ~err_clr;

            case (r_state)
                ST_IDLE: begin
                    if (w_n_low == 3'd1) begin
                        r_state   <= ST_LOW;
                        r_dev     <= low_index(w_s_wr_n);
                        r_low_cnt <= CNT_W'(1);
                        r_hold_a  <= w_s_a;
                        r_hold_d  <= w_s_d;
                    end else if (w_n_low > 3'd1) begin
                        err_collision <= 1'b1;
                        r_state       <= ST_DRAIN;
                    end
                end

                ST_LOW: begin
                    if (w_other_low) begin
                        err_collision <= 1'b1;
                        r_state       <= ST_DRAIN;
                    end else if (w_sel_low) begin
                        r_hold_a <= w_s_a;
                        r_hold_d <= w_s_d;
                        if (r_low_cnt < CNT_MIN)
                            r_low_cnt <= r_low_cnt + CNT_W'(1);
                    end else begin
                        r_state <= ST_IDLE;
                        if (!w_commit) begin
                            err_runt <= 1'b1;
                        end else if (!blank) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= w_waddr;
                            wr_char  <= r_hold_d;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (&w_s_wr_n)
                        r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Shadow RAM with write-first registered read; blank wins over a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram   <= {HPDL_NUM_CHAR{BLANK_CHAR}};
            rd_char <= BLANK_CHAR;
        end else if (blank) begin
            r_ram   <= {HPDL_NUM_CHAR{BLANK_CHAR}};
            rd_char <= BLANK_CHAR;
        end else begin
            if (w_ram_we)
                r_ram[w_waddr] <= r_hold_d;
            rd_char <= (w_ram_we && (rd_addr == w_waddr)) ? r_hold_d : r_ram[rd_addr];
        end
    end

endmodule

// File: doc/hpdl_bus_receiver.md
Name: hpdl_bus_receiver

Overview:
Display-side end of the HPDL-1414 parallel write bus. It samples the D[6:0], A[1:0] and WR_N[3:0] lines, which are asynchronous to clk, and detects completed write strobes. Each valid write is committed into a 16-character shadow RAM that mirrors four HPDL-1414 devices. Used as an on-board loopback/monitor for the display driver and as a checker target in simulation.

Parameters:
MIN_WR_LOW, 2, minimum synchronized WR_N low time in clk cycles for a write to be accepted (>=1)
SYNC_STAGES, 2, flip-flop depth of the input synchronizer (>=2)
BLANK_CHAR, 7'h20, reset/clear value of every shadow-RAM entry (ASCII space)

Ports:
clk  in  1  system clock (12 MHz on IceBreaker)
rst_n  in  1  asynchronous active-low reset
hpdl_d  in  7  display data bus D6..D0 (async)
hpdl_a  in  2  digit address A1..A0 (async)
hpdl_wr_n  in  4  per-device write strobes WR4..WR1, active low (async)
rd_addr  in  4  shadow-RAM read address {device[1:0], digit[1:0]}
rd_char  out  7  character at rd_addr, registered
wr_valid  out  1  one-cycle pulse per accepted write
wr_addr  out  4  {device, digit} of the accepted write, held until the next accepted write
wr_char  out  7  character of the accepted write, held until the next accepted write
err_runt  out  1  sticky: a strobe shorter than MIN_WR_LOW was seen
err_collision  out  1  sticky: more than one WR_N low at the same time
err_clr  in  1  synchronous clear of both sticky errors
blank  in  1  synchronous fill of all 16 entries with BLANK_CHAR

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: FSM=IDLE; rd_char=BLANK_CHAR; wr_valid=0; wr_addr=0; wr_char=BLANK_CHAR; errors=0; RAM=BLANK_CHAR; synchronizers=idle, with WR_N=4'hF and D/A=0.
- Synchronization: all 13 bus lines pass through SYNC_STAGES flops. Everything below refers to the synchronized signals (s_*).
- Device index: WR1 is device 0 and WR4 is device 3. Bit 0 of hpdl_wr_n is WR1.
- FSM IDLE:
  - Exactly one s_wr_n bit low → LOW, latch dev, low_cnt=1.
  - More than one bit low → set err_collision, go to DRAIN.
- FSM LOW: each cycle capture {s_a, s_d} into a hold register while the selected WR stays low; low_cnt saturates at MIN_WR_LOW.
  - Selected WR rises and low_cnt>=MIN_WR_LOW → commit hold register (last value sampled while low) to RAM[{dev,a}]. Pulse wr_valid in the same cycle as the RAM write. Update wr_addr/wr_char. Go to IDLE.
  - Selected WR rises and low_cnt<MIN_WR_LOW → set err_runt, no write, go to IDLE.
  - Any other WR goes low while in LOW → set err_collision, abort with no write, go to DRAIN.
- FSM DRAIN: wait until s_wr_n==4'hF, then go to IDLE.
- Throughput: a strobe may go low again in the cycle after the commit cycle; there is no dead time beyond the IDLE cycle.
- Read port: rd_char = RAM[rd_addr] registered, 1-cycle latency.
  - If rd_addr equals the address being committed in the same cycle, rd_char returns the new value the next cycle (write-first).
- blank: writes all 16 entries in one cycle and takes priority over a simultaneous commit. That commit is dropped, wr_valid is not pulsed, and the FSM still returns to IDLE.
- err_clr: a simultaneous error-setting event wins, so the flag stays 1.
- Reset asserted mid-strobe: FSM returns to IDLE asynchronously. A WR_N still low after release is treated as a new strobe, and low_cnt restarts from reset release.

Decomposition:
- Shared package hpdl_pkg:
  - HPDL_NUM_DEV=4, HPDL_NUM_DIGIT=4, HPDL_DATA_W=7, HPDL_ADDR_W=4
  - FSM state encoding {IDLE, LOW, DRAIN}
  - BLANK_CHAR default
- One natural sub-module: hpdl_sync, a parameterized N-bit, SYNC_STAGES-deep synchronizer with async active-low reset and a per-bit reset value.

Test Plan:
- Write 'A' (7'h41) on WR2 (hpdl_wr_n=4'b1101), a=2'd3, low 4 cycles → one wr_valid pulse, wr_addr=4'h7, wr_char=7'h41; rd_addr=7 returns 7'h41 one cycle later.
- 16 back-to-back writes of "HELLO WORLD 1234" across all devices/digits → 16 wr_valid pulses; reading 0..15 returns the string exactly; no error flags.
- 1-cycle WR1 pulse with MIN_WR_LOW=2 → no wr_valid, RAM unchanged (7'h20), err_runt=1; after err_clr it reads 0.
- WR1 and WR3 low together (4'b1010), then WR3 low while WR2 strobing → err_collision=1, no commit in either case; FSM accepts the next clean WR4 write.
- D changes from 7'h30 to 7'h31 two cycles before WR rises → committed char is 7'h31.
- blank asserted in the commit cycle of 'Z' at addr 5, and rst_n pulsed low mid-strobe → all entries 7'h20, no wr_valid for either; outputs match reset values during reset.
